// File: rtl/sys_bridge.sv
// CPU-to-device system bridge: decodes device and controller windows, returns registered read data,
// flags unmapped accesses, and synchronises, latches and masks device interrupts onto HWInt[7:2].
module sys_bridge #(
    parameter int          NDEV        = 3,
    parameter logic [31:0] BASE        = 32'h00007F00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:2]            PrAddr,
    input  logic [3:0]             BE,
    input  logic [31:0]            PrWD,
    input  logic                   We,
    output logic [31:0]            PrRD,
    output logic                   BusErr,
    output logic [7:2]             HWInt,
    output logic [1:0]             DEV_Addr,
    output logic [31:0]            DEV_WD,
    output logic [3:0]             DEV_BE,
    output logic [NDEV-1:0]        DEV_We,
    input  logic [32*NDEV-1:0]     DEV_RD,
    input  logic [NDEV-1:0]        DEV_Irq
);

    logic [31:0]     w_byte_addr;
    logic [31:0]     w_off;
    logic            w_above;
    logic [NDEV-1:0] w_hit;
    logic            w_dev_hit;
    logic            w_ctl_hit;
    logic            w_unmapped;
    logic            w_ctl_we;
    logic [31:0]     w_rd;
    logic [NDEV-1:0] w_clr;
    logic [NDEV-1:0] w_s;
    logic [NDEV-1:0] w_ip_next;

    logic [NDEV-1:0] r_im;
    logic [NDEV-1:0] r_ip;
    logic [NDEV-1:0] r_mode;
    logic [NDEV-1:0] r_sync [SYNC_STAGES];
    logic [NDEV-1:0] r_s_d;
    logic [NDEV-1:0] r_arm;
    logic            r_live;
    logic [31:0]     r_prrd;
    logic            r_buserr;
    logic [7:2]      r_hwint;

    assign w_byte_addr = {PrAddr, 2'b00};
    assign w_above     = (w_byte_addr >= BASE);
    assign w_off       = w_byte_addr - BASE;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NDEV; i++) begin
            w_hit[i] = w_above && (w_off[31:4] == 28'(i));
        end
    end

    assign w_dev_hit  = |w_hit;
    assign w_ctl_hit  = w_above && (w_off[31:4] == 28'hF) && (w_off[3:2] != 2'd3);
    assign w_unmapped = w_above && !w_dev_hit && !w_ctl_hit;
    assign w_ctl_we   = We && BE[0] && w_ctl_hit;

    assign DEV_We   = We ? w_hit : '0;
    assign DEV_Addr = PrAddr[3:2];
    assign DEV_WD   = PrWD;
    assign DEV_BE   = BE;

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (w_hit[i]) w_rd = DEV_RD[32*i +: 32];
        end
        if (w_ctl_hit) begin
            case (w_off[3:2])
                2'd0:    w_rd = 32'(r_im);
                2'd1:    w_rd = 32'(r_ip);
                2'd2:    w_rd = 32'(r_mode);
                default: w_rd = '0;
            endcase
        end
    end

    assign w_s   = r_sync[SYNC_STAGES-1];
    assign w_clr = (w_ctl_we && (w_off[3:2] == 2'd1)) ? PrWD[NDEV-1:0] : '0;

    // r_arm blocks the reset-cleared synchroniser from faking a rising edge on a line held high through reset.
    always_comb begin
        w_ip_next = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (r_mode[i]) w_ip_next[i] = (w_s[i] & ~r_s_d[i] & r_arm[i]) | (r_ip[i] & ~w_clr[i]);
            else           w_ip_next[i] = w_s[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= DEV_Irq;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im     <= '0;
            r_ip     <= '0;
            r_mode   <= '0;
            r_s_d    <= '0;
            r_arm    <= '0;
            r_live   <= 1'b0;
            r_prrd   <= '0;
            r_buserr <= 1'b0;
            r_hwint  <= '0;
        end else begin
            r_prrd   <= w_rd;
            r_buserr <= w_unmapped;
            r_hwint  <= 6'(r_ip & r_im);
            r_ip     <= w_ip_next;
            r_s_d    <= w_s;
            r_live   <= 1'b1;
            if (r_live) r_arm <= r_arm | ~r_sync[0];
            if (w_ctl_we && (w_off[3:2] == 2'd0)) r_im   <= PrWD[NDEV-1:0];
            if (w_ctl_we && (w_off[3:2] == 2'd2)) r_mode <= PrWD[NDEV-1:0];
        end
    end

    assign PrRD   = r_prrd;
    assign BusErr = r_buserr;
    assign HWInt  = r_hwint;

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: decode/read vector table, interrupt corner sequences,
// and randomized traffic checked against a sample-history reference model.
module tb_sys_bridge;

    localparam int          NDEV = 3;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h00007F00;
    localparam logic [31:0] A_IM   = BASE + 32'hF0;
    localparam logic [31:0] A_IP   = BASE + 32'hF4;
    localparam logic [31:0] A_MODE = BASE + 32'hF8;
    localparam logic [31:0] A_IDLE = BASE - 32'h4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [31:2]          addr;
    logic [3:0]           be;
    logic [31:0]          wd;
    logic                 we;
    logic [31:0]          prrd;
    logic                 buserr;
    logic [7:2]           hwint;
    logic [1:0]           dev_addr;
    logic [31:0]          dev_wd;
    logic [3:0]           dev_be;
    logic [NDEV-1:0]      dev_we;
    logic [32*NDEV-1:0]   dev_rd;
    logic [NDEV-1:0]      dev_irq;

    int n_vec = 0;
    int n_err = 0;

    sys_bridge #(.NDEV(NDEV), .BASE(BASE), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(rst_n), .PrAddr(addr), .BE(be), .PrWD(wd), .We(we),
        .PrRD(prrd), .BusErr(buserr), .HWInt(hwint), .DEV_Addr(dev_addr),
        .DEV_WD(dev_wd), .DEV_BE(dev_be), .DEV_We(dev_we), .DEV_RD(dev_rd), .DEV_Irq(dev_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0]     b;
        logic            w;
        logic [3:0]      e;
        logic [31:0]     d;
        logic [NDEV-1:0] e_we;
        logic [31:0]     e_rd;
        logic            e_err;
    } vec_t;

    vec_t tbl[$];

    logic [NDEV-1:0] m_im, m_ip, m_mode;
    logic [NDEV:0]   m_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic w, input logic [3:0] e, input logic [31:0] d);
        addr = b[31:2];
        we   = w;
        be   = e;
        wd   = d;
    endtask

    task automatic idle();
        drive(A_IDLE, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] b, input logic [31:0] d);
        drive(b, 1'b1, 4'hF, d);
        tick();
        idle();
    endtask

    task automatic rd_reg(input logic [31:0] b, output logic [31:0] v);
        drive(b, 1'b0, 4'hF, 32'h0);
        tick();
        v = prrd;
        idle();
    endtask

    task automatic wait_hw(input int bitn, input logic val, input string name);
        int n = 0;
        while (hwint[bitn] !== val && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(hwint[bitn]), 32'(val));
    endtask

    task automatic do_reset(input logic [NDEV-1:0] irq_v);
        dev_irq = irq_v;
        we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_prrd", prrd, 32'h0);
        chk("reset_buserr", 32'(buserr), 32'h0);
        chk("reset_hwint", 32'(hwint), 32'h0);
        drive(BASE + 32'h20, 1'b0, 4'hF, 32'h0);
        tick();
        tick();
        chk("reset_hold_prrd", prrd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rnd_step();
        logic [31:0]     b, off, exp_rd;
        logic            exp_err;
        logic [NDEV-1:0] exp_we, clr, nip;
        logic [7:2]      exp_hw;
        logic [NDEV:0]   sc, sp;
        int              idx, wsel;
        bit              ctl;
        if ($urandom_range(0, 3) == 0) b = A_IM + 32'(4 * $urandom_range(0, 3));
        else b = BASE - 32'h40 + (32'($urandom_range(0, 319)) & 32'hFFFF_FFFC);
        drive(b, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        for (int i = 0; i < NDEV; i++) dev_rd[32*i +: 32] = $urandom;
        if ($urandom_range(0, 7) == 0) dev_irq = NDEV'($urandom);
        #1;
        off = b - BASE; exp_rd = '0; exp_err = 1'b0; exp_we = '0; ctl = 1'b0; wsel = 0; idx = 0;
        if (b >= BASE) begin
            if (off < 32'(16 * NDEV)) begin
                idx = int'(off / 16);
                exp_rd = dev_rd[32*idx +: 32];
                if (we) exp_we[idx] = 1'b1;
            end else if (off >= 32'hF0 && off <= 32'hFB) begin
                ctl = 1'b1;
                wsel = int'((off - 32'hF0) / 4);
                exp_rd = (wsel == 0) ? 32'(m_im) : (wsel == 1) ? 32'(m_ip) : 32'(m_mode);
            end else begin
                exp_err = 1'b1;
            end
        end
        chk("rnd_dev_we", 32'(dev_we), 32'(exp_we));
        chk("rnd_dev_addr", 32'(dev_addr), 32'(b[3:2]));
        chk("rnd_dev_wd_be", {dev_wd[27:0], dev_be}, {wd[27:0], be});
        exp_hw = 6'(m_ip & m_im);
        clr = (ctl && we && be[0] && wsel == 1) ? wd[NDEV-1:0] : '0;
        m_hist.push_back({1'b1, dev_irq});
        sc = m_hist[m_hist.size() - 1 - S];
        sp = m_hist[m_hist.size() - 2 - S];
        for (int i = 0; i < NDEV; i++) begin
            if (m_mode[i]) nip[i] = (sc[NDEV] & sc[i] & sp[NDEV] & ~sp[i]) | (m_ip[i] & ~clr[i]);
            else           nip[i] = sc[NDEV] & sc[i];
        end
        tick();
        chk("rnd_prrd", prrd, exp_rd);
        chk("rnd_buserr", 32'(buserr), 32'(exp_err));
        chk("rnd_hwint", 32'(hwint), 32'(exp_hw));
        m_ip = nip;
        if (ctl && we && be[0] && wsel == 0) m_im = wd[NDEV-1:0];
        if (ctl && we && be[0] && wsel == 2) m_mode = wd[NDEV-1:0];
        void'(m_hist.pop_front());
    endtask

    initial begin
        logic [31:0] v;
        int n;
        addr = A_IDLE[31:2]; be = 4'h0; wd = '0; we = 1'b0; dev_irq = '0;
        dev_rd = {32'hA5A5_0001, 32'h2222_0001, 32'h1111_0000};

        tbl.push_back('{BASE + 32'h14, 1'b1, 4'hF, 32'hDEAD_0001, 3'b010, 32'h2222_0001, 1'b0});
        tbl.push_back('{BASE + 32'h20, 1'b0, 4'hF, 32'h0,         3'b000, 32'hA5A5_0001, 1'b0});
        tbl.push_back('{BASE + 32'h00, 1'b0, 4'hF, 32'h0,         3'b000, 32'h1111_0000, 1'b0});
        tbl.push_back('{BASE + 32'h10, 1'b0, 4'hF, 32'h0,         3'b000, 32'h2222_0001, 1'b0});
        tbl.push_back('{BASE + 32'hE0, 1'b0, 4'hF, 32'h0,         3'b000, 32'h0,         1'b1});
        tbl.push_back('{BASE - 32'h4,  1'b1, 4'hF, 32'h1234_5678, 3'b000, 32'h0,         1'b0});
        tbl.push_back('{BASE + 32'h30, 1'b1, 4'hF, 32'h1234_5678, 3'b000, 32'h0,         1'b1});
        tbl.push_back('{A_IM,          1'b1, 4'h1, 32'hFFFF_FFFF, 3'b000, 32'h0,         1'b0});
        tbl.push_back('{A_IM,          1'b0, 4'hF, 32'h0,         3'b000, 32'h7,         1'b0});
        tbl.push_back('{A_MODE,        1'b1, 4'hE, 32'h5,         3'b000, 32'h0,         1'b0});
        tbl.push_back('{A_MODE,        1'b0, 4'hF, 32'h0,         3'b000, 32'h0,         1'b0});
        tbl.push_back('{A_MODE,        1'b1, 4'h1, 32'h5,         3'b000, 32'h0,         1'b0});
        tbl.push_back('{A_MODE,        1'b0, 4'hF, 32'h0,         3'b000, 32'h5,         1'b0});
        tbl.push_back('{BASE + 32'hFC, 1'b0, 4'hF, 32'h0,         3'b000, 32'h0,         1'b1});
        tbl.push_back('{A_IP,          1'b1, 4'hF, 32'h7,         3'b000, 32'h0,         1'b0});
        tbl.push_back('{BASE + 32'h2C, 1'b1, 4'hF, 32'h0,         3'b100, 32'hA5A5_0001, 1'b0});
        tbl.push_back('{A_IM,          1'b1, 4'h1, 32'h0,         3'b000, 32'h7,         1'b0});
        tbl.push_back('{A_MODE,        1'b1, 4'h1, 32'h0,         3'b000, 32'h5,         1'b0});
        tbl.push_back('{BASE + 32'hFC, 1'b1, 4'hF, 32'hFFFF_FFFF, 3'b000, 32'h0,         1'b1});
        tbl.push_back('{A_IM,          1'b0, 4'hF, 32'h0,         3'b000, 32'h0,         1'b0});

        do_reset('0);
        foreach (tbl[k]) begin
            drive(tbl[k].b, tbl[k].w, tbl[k].e, tbl[k].d);
            #1;
            chk($sformatf("tbl%0d_dev_we", k), 32'(dev_we), 32'(tbl[k].e_we));
            chk($sformatf("tbl%0d_dev_addr", k), 32'(dev_addr), 32'(tbl[k].b[3:2]));
            tick();
            chk($sformatf("tbl%0d_prrd", k), prrd, tbl[k].e_rd);
            chk($sformatf("tbl%0d_buserr", k), 32'(buserr), 32'(tbl[k].e_err));
            chk($sformatf("tbl%0d_hwint", k), 32'(hwint), 32'h0);
        end
        idle();

        // Edge-mode pulse, then write-1-clear and its two-edge effect on HWInt.
        do_reset('0);
        wr(A_MODE, 32'h1);
        wr(A_IM, 32'h1);
        dev_irq[0] = 1'b1;
        tick();
        dev_irq[0] = 1'b0;
        wait_hw(2, 1'b1, "edge_pulse_hwint2");
        rd_reg(A_IP, v);
        chk("edge_pulse_ip", v, 32'h1);
        drive(A_IP, 1'b1, 4'hF, 32'h1);
        tick();
        idle();
        chk("w1c_hwint_still_high", 32'(hwint[2]), 32'h1);
        tick();
        chk("w1c_hwint_low", 32'(hwint[2]), 32'h0);
        rd_reg(A_IP, v);
        chk("w1c_ip_cleared", v, 32'h0);

        // W1C lands on the same edge that sets IP[0]: set wins.
        dev_irq[0] = 1'b1;
        repeat (S) tick();
        drive(A_IP, 1'b1, 4'h1, 32'h1);
        tick();
        idle();
        chk("same_edge_hwint_pre", 32'(hwint[2]), 32'h0);
        tick();
        chk("same_edge_hwint_post", 32'(hwint[2]), 32'h1);
        rd_reg(A_IP, v);
        chk("same_edge_ip", v, 32'h1);
        dev_irq[0] = 1'b0;

        // Level mode follow and release latency, then async reset while HWInt is high.
        wr(A_MODE, 32'h0);
        wr(A_IM, 32'h4);
        dev_irq[2] = 1'b1;
        wait_hw(4, 1'b1, "level_hwint4_high");
        dev_irq[2] = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (hwint[4] === 1'b1 && n < 20);
        chk("level_release_edges", 32'(n), 32'(S + 2));
        dev_irq[2] = 1'b1;
        wait_hw(4, 1'b1, "level_hwint4_again");
        drive(BASE + 32'h20, 1'b0, 4'hF, 32'h0);
        tick();
        chk("pre_reset_prrd", prrd, 32'hA5A5_0001);
        do_reset(3'b010);

        // DEV_Irq[1] held high through reset release must not set IP in edge mode.
        wr(A_MODE, 32'h2);
        repeat (8) tick();
        rd_reg(A_IP, v);
        chk("held_through_reset_ip", v, 32'h0);
        dev_irq[1] = 1'b0;
        repeat (5) tick();
        dev_irq[1] = 1'b1;
        repeat (6) tick();
        rd_reg(A_IP, v);
        chk("new_edge_after_reset_ip", v, 32'h2);

        do_reset('0);
        m_im = '0; m_ip = '0; m_mode = '0;
        m_hist.delete();
        for (int i = 0; i < S + 1; i++) m_hist.push_back('0);
        for (int t = 0; t < 600; t++) rnd_step();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sys_bridge.md
SYS_BRIDGE -- requirements
Module: sys_bridge

Interface
REQ-001 Parameter NDEV, default 3: number of device channels; legal range 1..6.
REQ-002 Parameter BASE, default 32'h00007F00: byte address of device window 0.
REQ-003 Parameter SYNC_STAGES, default 2: interrupt synchroniser depth; legal range 2..3.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 PrAddr  in  30  CPU word address [31:2].
REQ-007 BE  in  4  CPU byte enables.
REQ-008 PrWD  in  32  CPU write data.
REQ-009 We  in  1  CPU write strobe, one cycle per write.
REQ-010 PrRD  out  32  registered read data to CPU.
REQ-011 BusErr  out  1  one-cycle pulse on an unmapped access.
REQ-012 HWInt  out  6  interrupt lines [7:2] to CPU.
REQ-013 DEV_Addr  out  2  word offset within the device window (PrAddr[3:2]).
REQ-014 DEV_WD / DEV_BE  out  32 / 4  PrWD and BE passed through.
REQ-015 DEV_We  out  NDEV  per-device write strobe.
REQ-016 DEV_RD  in  32*NDEV  read data, flattened; device i at bits [32i+31:32i].
REQ-017 DEV_Irq  in  NDEV  asynchronous device interrupt requests.

Function
REQ-018 Address decode: device i hit when byte address is in BASE+16i .. BASE+16i+15.
REQ-019 Controller window: BASE+0xF0 .. BASE+0xFB.
- word0 IM: mask, NDEV bits, read/write.
- word1 IP: pending, read; write-1-to-clear.
- word2 MODE: bit i=1 selects edge mode, 0 selects level mode; read/write.
REQ-020 Access validity: an access is an access only when the address is at or above BASE; an address below BASE is ignored with no BusErr and PrRD=0; any other address at or above BASE that is not a hit is unmapped.
REQ-021 DEV_We[i] is combinational: We & hit_i; at most one bit is high.
REQ-022 Controller register writes occur at the clock edge with We=1 and BE[0]=1; only bits [NDEV-1:0] are stored; BE[0]=0 suppresses the write.
REQ-023 Read latency is exactly 1 cycle: at every edge PrRD loads the data selected by the current PrAddr.
- Device hit: DEV_RD slice.
- Controller registers: zero-extended value.
- Unmapped or below BASE: 0.
REQ-024 BusErr registers 1 for exactly one cycle after any cycle presenting an unmapped address at or above BASE, with or without We; an unmapped write has no side effects.
REQ-025 Each DEV_Irq bit passes through a SYNC_STAGES flip-flop synchroniser; s[i] denotes the synchronised output.
REQ-026 Edge mode: IP[i] sets on the cycle after s[i] goes 0->1 and holds until write-1-clear.
REQ-027 Level mode: IP[i] equals s[i] delayed one cycle; write-1-clear has no effect.
REQ-028 Same-edge set and write-1-clear of one IP bit: set wins, IP stays 1.
REQ-029 A MODE change takes effect on the next edge; switching level to edge does not clear IP.
REQ-030 HWInt[2+i] is registered: IP[i] & IM[i], one cycle after IP/IM update; HWInt bits at or above 2+NDEV are constant 0.
REQ-031 No internal state wraps or saturates; all counters are absent, and registers are bit-level.

Reset
REQ-032 reset=0 asynchronously clears: IM=0, IP=0, MODE=0, synchroniser stages, PrRD=0, BusErr=0, HWInt=0.
REQ-033 Reset assertion mid-access aborts the access; reset deassertion is seen at the next edge, and the first post-reset edge already behaves per REQ-023.
REQ-034 A DEV_Irq held high through reset release in edge mode produces no IP set until a new 0->1 transition occurs.

Verification
REQ-035 Write PrAddr=BASE+0x14 (device 1, offset 1) with We=1 -> DEV_We=3'b010, DEV_Addr=1 in the same cycle; other DEV_We bits stay 0.
REQ-036 DEV_RD slice 2=32'hA5A5_0001, read BASE+0x20 -> PrRD=32'hA5A5_0001 exactly one edge later.
REQ-037 Read BASE+0xE0 (NDEV=3) -> BusErr high for one cycle, PrRD=0.
REQ-038 MODE=3'b001, IM=3'b001, pulse DEV_Irq[0] -> IP[0]=1 and HWInt[2]=1; write IP=1 -> HWInt[2]=0 two edges after the write edge.
REQ-039 Edge mode: W1C of IP[0] on the same edge as a new set -> IP[0] remains 1.
REQ-040 Level mode, IM=3'b100, hold DEV_Irq[2]=1 -> HWInt[4]=1; release -> HWInt[4]=0 after SYNC_STAGES+2 edges; reset=0 at any point clears HWInt immediately.
